// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl: capture/readout sequencer for the FIR-output BRAM.
// On a trigger rising edge it writes DEPTH consecutive valid samples to
// addresses 0..DEPTH-1. It then holds the buffer and sweeps it out on a
// read-start rising edge. The read-data qualifiers are aligned to the BRAM
// read latency.
//
// Ports:
//   clock, i_reset       system clock; synchronous active-high reset
//   i_trigger            capture request (rising edge used)
//   i_sample_valid       FIR sample valid this cycle
//   i_clear              discard buffer, return to IDLE
//   i_read_start         readout request (rising edge used)
//   i_read_enable        readout advance / stall
//   o_wr_en, o_wr_addr   BRAM write port control
//   o_rd_en, o_rd_addr   BRAM read port control
//   o_rd_valid           BRAM read data valid this cycle
//   o_rd_last            qualifies the final readout word
//   o_full, o_busy       buffer complete / capture in progress
//   o_state              IDLE=0, CAPTURE=1, FULL=2, READOUT=3
module bram_capture_ctrl #(
  parameter int unsigned NB_ADDR    = 11,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_trigger,
  input  logic               i_sample_valid,
  input  logic               i_clear,
  input  logic               i_read_start,
  input  logic               i_read_enable,
  output logic               o_wr_en,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic               o_rd_en,
  output logic [NB_ADDR-1:0] o_rd_addr,
  output logic               o_rd_valid,
  output logic               o_rd_last,
  output logic               o_full,
  output logic               o_busy,
  output logic [1:0]         o_state
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NB_ADDR-1:0]      wr_cnt_q, wr_cnt_d;
  logic [NB_ADDR-1:0]      rd_cnt_q, rd_cnt_d;
  logic                    trig_prev_q, trig_prev_d;
  logic                    start_prev_q, start_prev_d;
  logic [RD_LATENCY-1:0]   rd_valid_q, rd_valid_d;
  logic [RD_LATENCY-1:0]   rd_last_q, rd_last_d;
  logic                    trig_edge;
  logic                    start_edge;
  logic                    wr_en_c;
  logic                    rd_en_c;

  assign trig_edge  = i_trigger & ~trig_prev_q;
  assign start_edge = i_read_start & ~start_prev_q;

  // State, counters and read-qualifier pipeline.
  // The edge registers follow their inputs even during reset, so a level that
  // is already high when reset is released is not taken for a new edge.
  always_ff @(posedge clock) begin
    trig_prev_q  <= trig_prev_d;
    start_prev_q <= start_prev_d;
    if (i_reset) begin
      state_q    <= ST_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= '0;
      rd_last_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Next-state, counter and port-enable logic.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    trig_prev_d  = i_trigger;
    start_prev_d = i_read_start;
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    rd_valid_d   = '0;
    rd_last_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (trig_edge) begin
          state_d  = ST_CAPTURE;
          wr_cnt_d = '0;
        end
      end
      ST_CAPTURE: begin
        wr_en_c = i_sample_valid;
        // Counter stops at the last address; it never wraps.
        if (i_sample_valid) begin
          if (wr_cnt_q == LAST_ADDR) state_d = ST_FULL;
          else                       wr_cnt_d = wr_cnt_q + NB_ADDR'(1);
        end
      end
      ST_FULL: begin
        if (start_edge) begin
          state_d  = ST_READOUT;
          rd_cnt_d = '0;
        end
      end
      ST_READOUT: begin
        rd_en_c = i_read_enable;
        if (i_read_enable) begin
          if (rd_cnt_q == LAST_ADDR) state_d = ST_FULL;
          else                       rd_cnt_d = rd_cnt_q + NB_ADDR'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear beats trigger/start/advance, including in IDLE.
    if (i_clear) begin
      state_d  = ST_IDLE;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      wr_en_c  = 1'b0;
      rd_en_c  = 1'b0;
    end

    if (i_reset) begin
      wr_en_c = 1'b0;
      rd_en_c = 1'b0;
    end

    // Valid/last ride a shift register matching the BRAM read latency.
    rd_valid_d[0] = rd_en_c;
    rd_last_d[0]  = rd_en_c & (rd_cnt_q == LAST_ADDR);
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      rd_valid_d[i] = rd_valid_q[i-1];
      rd_last_d[i]  = rd_last_q[i-1];
    end
  end

  assign o_wr_en    = wr_en_c;
  assign o_wr_addr  = wr_cnt_q;
  assign o_rd_en    = rd_en_c;
  assign o_rd_addr  = rd_cnt_q;
  assign o_rd_valid = rd_valid_q[RD_LATENCY-1];
  assign o_rd_last  = rd_last_q[RD_LATENCY-1];
  assign o_full     = (state_q == ST_FULL) || (state_q == ST_READOUT);
  assign o_busy     = (state_q == ST_CAPTURE);
  assign o_state    = state_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Bench for bram_capture_ctrl: a DEPTH=8 instance and a DEPTH=2048 instance
// share one set of inputs. Each instance is compared every cycle against a
// behavioural model of its capture/readout rules. A bench-side BRAM also
// checks that read-back data matches what was captured.
module tb_bram_capture_ctrl;

  localparam int unsigned NA_A = 4;
  localparam int unsigned DEP_A = 8;
  localparam int unsigned NA_B = 11;
  localparam int unsigned DEP_B = 2048;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic i_reset = 1'b0, i_trigger = 1'b0, i_sample_valid = 1'b0;
  logic i_clear = 1'b0, i_read_start = 1'b0, i_read_enable = 1'b0;
  logic [15:0] sample_data = 16'h0;

  logic            wr_en_a, rd_en_a, rd_valid_a, rd_last_a, full_a, busy_a;
  logic [NA_A-1:0] wr_addr_a, rd_addr_a;
  logic [1:0]      state_a;
  logic            wr_en_b, rd_en_b, rd_valid_b, rd_last_b, full_b, busy_b;
  logic [NA_B-1:0] wr_addr_b, rd_addr_b;
  logic [1:0]      state_b;

  bram_capture_ctrl #(.NB_ADDR(NA_A), .DEPTH(DEP_A), .RD_LATENCY(1)) dut_a (
    .clock(clock), .i_reset(i_reset), .i_trigger(i_trigger),
    .i_sample_valid(i_sample_valid), .i_clear(i_clear),
    .i_read_start(i_read_start), .i_read_enable(i_read_enable),
    .o_wr_en(wr_en_a), .o_wr_addr(wr_addr_a), .o_rd_en(rd_en_a),
    .o_rd_addr(rd_addr_a), .o_rd_valid(rd_valid_a), .o_rd_last(rd_last_a),
    .o_full(full_a), .o_busy(busy_a), .o_state(state_a));

  bram_capture_ctrl #(.NB_ADDR(NA_B), .DEPTH(DEP_B), .RD_LATENCY(1)) dut_b (
    .clock(clock), .i_reset(i_reset), .i_trigger(i_trigger),
    .i_sample_valid(i_sample_valid), .i_clear(i_clear),
    .i_read_start(i_read_start), .i_read_enable(i_read_enable),
    .o_wr_en(wr_en_b), .o_wr_addr(wr_addr_b), .o_rd_en(rd_en_b),
    .o_rd_addr(rd_addr_b), .o_rd_valid(rd_valid_b), .o_rd_last(rd_last_b),
    .o_full(full_b), .o_busy(busy_b), .o_state(state_b));

  // Bench-side BRAMs driven only by the DUT ports.
  logic [15:0] bram_a [2**NA_A];
  logic [15:0] bram_b [2**NA_B];
  logic [15:0] rdata_a, rdata_b;
  always @(posedge clock) begin
    if (wr_en_a) bram_a[wr_addr_a] <= sample_data;
    if (rd_en_a) rdata_a <= bram_a[rd_addr_a];
    if (wr_en_b) bram_b[wr_addr_b] <= sample_data;
    if (rd_en_b) rdata_b <= bram_b[rd_addr_b];
  end

  // Behavioural model: phase 0 idle, 1 capturing, 2 holding, 3 reading out.
  int          total = 0, bad = 0;
  int          dep [2] = '{DEP_A, DEP_B};
  int          m_st [2] = '{0, 0};
  int          m_wr [2] = '{0, 0};
  int          m_rd [2] = '{0, 0};
  bit          m_tp [2] = '{0, 0};
  bit          m_sp [2] = '{0, 0};
  bit          m_rdv [2] = '{0, 0};
  bit          m_rdl [2] = '{0, 0};
  logic [15:0] m_rdat [2];
  logic [15:0] m_cap [2][2048];

  function automatic bit exp_wr(int k);
    return m_st[k] == 1 && i_sample_valid && !i_clear && !i_reset;
  endfunction

  function automatic bit exp_rd(int k);
    return m_st[k] == 3 && i_read_enable && !i_clear && !i_reset;
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      bit te, se, we, re;
      te = i_trigger && !m_tp[k];
      se = i_read_start && !m_sp[k];
      we = exp_wr(k);
      re = exp_rd(k);
      if (i_reset) begin
        m_st[k] = 0; m_wr[k] = 0; m_rd[k] = 0; m_rdv[k] = 0; m_rdl[k] = 0;
      end else begin
        m_rdv[k] = re;
        m_rdl[k] = re && (m_rd[k] == dep[k] - 1);
        if (re) m_rdat[k] = m_cap[k][m_rd[k]];
        if (i_clear) begin
          m_st[k] = 0; m_wr[k] = 0; m_rd[k] = 0;
        end else begin
          case (m_st[k])
            0: if (te) begin m_st[k] = 1; m_wr[k] = 0; end
            1: if (we) begin
                 m_cap[k][m_wr[k]] = sample_data;
                 if (m_wr[k] == dep[k] - 1) m_st[k] = 2;
                 else m_wr[k]++;
               end
            2: if (se) begin m_st[k] = 3; m_rd[k] = 0; end
            default: if (re) begin
                 if (m_rd[k] == dep[k] - 1) m_st[k] = 2;
                 else m_rd[k]++;
               end
          endcase
        end
      end
      m_tp[k] = i_trigger;
      m_sp[k] = i_read_start;
    end
  end

  function automatic logic [45:0] exp_vec(int k);
    return {(m_rdv[k] ? m_rdat[k] : 16'h0), exp_wr(k), 11'(m_wr[k]),
            exp_rd(k), 11'(m_rd[k]), m_rdv[k], m_rdl[k],
            (m_st[k] == 2 || m_st[k] == 3), (m_st[k] == 1), 2'(m_st[k])};
  endfunction

  function automatic logic [45:0] obs_vec(int k);
    if (k == 0)
      return {(rd_valid_a ? rdata_a : 16'h0), wr_en_a, 11'(wr_addr_a),
              rd_en_a, 11'(rd_addr_a), rd_valid_a, rd_last_a, full_a, busy_a, state_a};
    return {(rd_valid_b ? rdata_b : 16'h0), wr_en_b, wr_addr_b,
            rd_en_b, rd_addr_b, rd_valid_b, rd_last_b, full_b, busy_b, state_b};
  endfunction

  task automatic set_in(bit rst, bit trig, bit sv, bit clr, bit start, bit ren);
    i_reset = rst; i_trigger = trig; i_sample_valid = sv;
    i_clear = clr; i_read_start = start; i_read_enable = ren;
    sample_data = 16'($urandom);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      set_in(c < 5, c >= 2, 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      @(negedge clock);
      if (c > 0) begin
        for (int k = 0; k < 2; k++) begin
          total++;
          if (obs_vec(k) !== exp_vec(k)) begin
            bad++;
            $display("FAIL reset k=%0d c=%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
          end
        end
      end
    end
  endtask

  task automatic test_capture_basic();
    for (int c = 0; c < 14; c++) begin
      @(posedge clock); #1;
      set_in(1'b0, c == 1, c >= 1, 1'b0, 1'b0, 1'($urandom));
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL capture_basic k=%0d c=%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_gappy();
    for (int c = 0; c < 22; c++) begin
      @(posedge clock); #1;
      set_in(1'b0, c == 1, c[0], c == 0, 1'b0, 1'($urandom));
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL gappy k=%0d c=%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_readout_stall();
    for (int c = 0; c < 46; c++) begin
      bit ren;
      ren = (c < 24) ? ((c % 4) < 2) : ($urandom_range(3) != 0);
      @(posedge clock); #1;
      set_in(1'b0, 1'b0, 1'($urandom), 1'b0, (c >= 1 && c < 24) || c >= 25, ren);
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL readout_stall k=%0d c=%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_trigger_hygiene();
    for (int c = 0; c < 26; c++) begin
      @(posedge clock); #1;
      set_in(1'b0, (c < 10) ? 1'($urandom) : 1'b0, 1'b1, 1'b0, c == 10, c > 10);
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL trigger_hygiene k=%0d c=%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_clear_reset();
    int ph = 0;
    int tail = 0;
    for (int c = 0; c < 80 && !(ph == 7 && tail >= 4); c++) begin
      bit rst, trig, sv, clr, start, ren;
      rst = 0; trig = 0; sv = 0; clr = 0; start = 0; ren = 0;
      @(posedge clock); #1;
      case (ph)
        0: begin clr = 1; ph = 1; end
        1: begin trig = 1; ph = 2; end
        2: begin sv = 1; if (m_st[0] == 1 && m_wr[0] == 3) begin clr = 1; ph = 3; end end
        3: ph = 4;
        4: begin trig = 1; ph = 5; end
        5: begin sv = 1; if (m_st[0] == 2) begin start = 1; ph = 6; end end
        6: begin
             start = 1; ren = 1;
             if (m_st[0] == 3 && m_rd[0] == 5) begin rst = 1; ph = 7; end
           end
        default: tail++;
      endcase
      set_in(rst, trig, sv, clr, start, ren);
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL clear_reset k=%0d c=%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
    end
    total++;
    if (ph != 7) begin
      bad++;
      $display("FAIL clear_reset_timeout got phase=%0d exp phase=7", ph);
    end
  endtask

  task automatic test_full_size();
    int ph = 0;
    int wr_cnt = 0, rdv_cnt = 0, last_cnt = 0, tail = 0;
    int last_wr = -1;
    for (int c = 0; c < 6000 && !(ph == 3 && tail >= 3); c++) begin
      bit trig, sv, clr, start, ren;
      trig = 0; sv = 0; clr = 0; start = 0; ren = 0;
      @(posedge clock); #1;
      case (ph)
        0: begin clr = (c == 0); trig = (c == 1); if (c == 1) ph = 1; end
        1: begin
             sv = ($urandom_range(7) != 0); trig = 1'($urandom);
             if (m_st[1] == 2) begin start = 1; ph = 2; end
           end
        2: begin
             start = 1; ren = ($urandom_range(7) != 0);
             if (m_st[1] == 2) ph = 3;
           end
        default: tail++;
      endcase
      set_in(1'b0, trig, sv, clr, start, ren);
      @(negedge clock);
      if (wr_en_b) begin wr_cnt++; last_wr = int'(wr_addr_b); end
      if (rd_valid_b) rdv_cnt++;
      if (rd_last_b) last_cnt++;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL full_size k=%0d c=%0d got=%h exp=%h", k, c, obs_vec(k), exp_vec(k));
        end
      end
    end
    total++;
    if (wr_cnt != DEP_B || last_wr != DEP_B - 1) begin
      bad++;
      $display("FAIL full_size_writes got count=%0d last=%0d exp count=%0d last=%0d",
               wr_cnt, last_wr, DEP_B, DEP_B - 1);
    end
    total++;
    if (rdv_cnt != DEP_B || last_cnt != 1) begin
      bad++;
      $display("FAIL full_size_reads got valid=%0d last=%0d exp valid=%0d last=1",
               rdv_cnt, last_cnt, DEP_B);
    end
  endtask

  initial begin
    test_reset();
    test_capture_basic();
    test_gappy();
    test_readout_stall();
    test_trigger_hygiene();
    test_clear_reset();
    test_full_size();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
